cdb_arbiter: RTL and testbench

//  Shares the single common data bus between the ALU result producer and the LSB result

---
 rtl/cdb_arbiter_if.sv | 43 ++++
 rtl/cdb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Producer/consumer signal bundle for the common data bus arbiter.
// The slave modport is the arbiter side; the master modport is the ALU/LSB/RoB side.
interface cdb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH  = 8
);
  // Valid/ready: a producer holds xxx_en with its payload; the result is taken on a
  // rising edge where xxx_en=1 and the matching full=0. full is also high while frozen.
  logic                  ALUCDB_en;
  logic [RoB_WIDTH-1:0]  ALUCDB_RoB_index;
  logic [31:0]           ALUCDB_value;
  logic [ADDR_WIDTH-1:0] ALUCDB_next_pc;
  logic                  CDBALU_full;

  logic                  LSBCDB_en;
  logic [RoB_WIDTH-1:0]  LSBCDB_RoB_index;
  logic [31:0]           LSBCDB_value;
  logic                  CDBLSB_full;

  logic                  RoBCDB_flush;

  logic                  CDB_en;
  logic [RoB_WIDTH-1:0]  CDB_RoB_index;
  logic [31:0]           CDB_value;
  logic [ADDR_WIDTH-1:0] CDB_next_pc;
  logic                  CDB_src;

  modport slave (
    input  ALUCDB_en, ALUCDB_RoB_index, ALUCDB_value, ALUCDB_next_pc,
    input  LSBCDB_en, LSBCDB_RoB_index, LSBCDB_value,
    input  RoBCDB_flush,
    output CDBALU_full, CDBLSB_full,
    output CDB_en, CDB_RoB_index, CDB_value, CDB_next_pc, CDB_src
  );

  modport master (
    output ALUCDB_en, ALUCDB_RoB_index, ALUCDB_value, ALUCDB_next_pc,
    output LSBCDB_en, LSBCDB_RoB_index, LSBCDB_value,
    output RoBCDB_flush,
    input  CDBALU_full, CDBLSB_full,
    input  CDB_en, CDB_RoB_index, CDB_value, CDB_next_pc, CDB_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB between ALU and LSB results, with per-source FIFOs.
// Optional grant/conflict counters are enabled by defining CDB_ARB_STATS_EN.
module cdb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH  = 8,
  parameter int FIFO_WIDTH = 2
) (
  input  logic        Sys_clk,
  input  logic        Sys_rst,
  input  logic        Sys_rdy,
`ifdef CDB_ARB_STATS_EN
  output logic [31:0] Stat_alu_grants,
  output logic [31:0] Stat_lsb_grants,
  output logic [31:0] Stat_conflicts,
`endif
  cdb_arbiter_if.slave bus
);

  localparam int FIFO_DEPTH = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] DEPTH_CNT = (FIFO_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

  logic [RoB_WIDTH-1:0]  alu_idx_mem [FIFO_DEPTH];
  logic [31:0]           alu_val_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] alu_npc_mem [FIFO_DEPTH];
  logic [RoB_WIDTH-1:0]  lsb_idx_mem [FIFO_DEPTH];
  logic [31:0]           lsb_val_mem [FIFO_DEPTH];

  logic [FIFO_WIDTH-1:0] alu_head_q, alu_head_d, alu_tail_q, alu_tail_d;
  logic [FIFO_WIDTH-1:0] lsb_head_q, lsb_head_d, lsb_tail_q, lsb_tail_d;
  logic [FIFO_WIDTH:0]   alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  src_e                  last_grant_q, last_grant_d;

  logic                  cdb_en_q, cdb_en_d;
  logic [RoB_WIDTH-1:0]  cdb_idx_q, cdb_idx_d;
  logic [31:0]           cdb_val_q, cdb_val_d;
  logic [ADDR_WIDTH-1:0] cdb_npc_q, cdb_npc_d;
  logic                  cdb_src_q, cdb_src_d;

  logic alu_full, lsb_full, alu_push, lsb_push;
  logic arb_en, alu_ne, lsb_ne, grant_alu, grant_lsb;

  // Full comes from the registered count only, so a same-cycle pop never makes room.
  always_comb begin
    alu_full  = !Sys_rdy || (alu_cnt_q == DEPTH_CNT);
    lsb_full  = !Sys_rdy || (lsb_cnt_q == DEPTH_CNT);
    alu_push  = bus.ALUCDB_en && !alu_full && !bus.RoBCDB_flush;
    lsb_push  = bus.LSBCDB_en && !lsb_full && !bus.RoBCDB_flush;
    arb_en    = Sys_rdy && !bus.RoBCDB_flush;
    alu_ne    = (alu_cnt_q != '0);
    lsb_ne    = (lsb_cnt_q != '0);
    grant_alu = arb_en && alu_ne && (!lsb_ne || (last_grant_q == SRC_LSB));
    grant_lsb = arb_en && lsb_ne && !grant_alu;
  end

  always_comb begin
    alu_head_d   = alu_head_q + FIFO_WIDTH'(grant_alu);
    alu_tail_d   = alu_tail_q + FIFO_WIDTH'(alu_push);
    alu_cnt_d    = alu_cnt_q + (FIFO_WIDTH + 1)'(alu_push) - (FIFO_WIDTH + 1)'(grant_alu);
    lsb_head_d   = lsb_head_q + FIFO_WIDTH'(grant_lsb);
    lsb_tail_d   = lsb_tail_q + FIFO_WIDTH'(lsb_push);
    lsb_cnt_d    = lsb_cnt_q + (FIFO_WIDTH + 1)'(lsb_push) - (FIFO_WIDTH + 1)'(grant_lsb);
    last_grant_d = last_grant_q;
    cdb_en_d     = grant_alu || grant_lsb;
    cdb_idx_d    = cdb_idx_q;
    cdb_val_d    = cdb_val_q;
    cdb_npc_d    = cdb_npc_q;
    cdb_src_d    = cdb_src_q;
    if (grant_alu) begin
      last_grant_d = SRC_ALU;
      cdb_idx_d    = alu_idx_mem[alu_head_q];
      cdb_val_d    = alu_val_mem[alu_head_q];
      cdb_npc_d    = alu_npc_mem[alu_head_q];
      cdb_src_d    = SRC_ALU;
    end else if (grant_lsb) begin
      last_grant_d = SRC_LSB;
      cdb_idx_d    = lsb_idx_mem[lsb_head_q];
      cdb_val_d    = lsb_val_mem[lsb_head_q];
      cdb_npc_d    = '0;
      cdb_src_d    = SRC_LSB;
    end
    // Flush empties both queues but keeps the round-robin pointer where it was.
    if (bus.RoBCDB_flush) begin
      alu_head_d = '0;
      alu_tail_d = '0;
      alu_cnt_d  = '0;
      lsb_head_d = '0;
      lsb_tail_d = '0;
      lsb_cnt_d  = '0;
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (alu_push) begin
      alu_idx_mem[alu_tail_q] <= bus.ALUCDB_RoB_index;
      alu_val_mem[alu_tail_q] <= bus.ALUCDB_value;
      alu_npc_mem[alu_tail_q] <= bus.ALUCDB_next_pc;
    end
    if (lsb_push) begin
      lsb_idx_mem[lsb_tail_q] <= bus.LSBCDB_RoB_index;
      lsb_val_mem[lsb_tail_q] <= bus.LSBCDB_value;
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      alu_head_q   <= '0;
      alu_tail_q   <= '0;
      alu_cnt_q    <= '0;
      lsb_head_q   <= '0;
      lsb_tail_q   <= '0;
      lsb_cnt_q    <= '0;
      last_grant_q <= SRC_LSB;
      cdb_en_q     <= 1'b0;
      cdb_idx_q    <= '0;
      cdb_val_q    <= '0;
      cdb_npc_q    <= '0;
      cdb_src_q    <= 1'b0;
    end else begin
      alu_head_q   <= alu_head_d;
      alu_tail_q   <= alu_tail_d;
      alu_cnt_q    <= alu_cnt_d;
      lsb_head_q   <= lsb_head_d;
      lsb_tail_q   <= lsb_tail_d;
      lsb_cnt_q    <= lsb_cnt_d;
      last_grant_q <= last_grant_d;
      cdb_en_q     <= cdb_en_d;
      cdb_idx_q    <= cdb_idx_d;
      cdb_val_q    <= cdb_val_d;
      cdb_npc_q    <= cdb_npc_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] stat_alu_q, stat_alu_d, stat_lsb_q, stat_lsb_d, stat_conf_q, stat_conf_d;

  // Grants and arb_en are already zero while frozen or flushing, so counters hold then.
  always_comb begin
    stat_alu_d  = stat_alu_q + 32'(grant_alu);
    stat_lsb_d  = stat_lsb_q + 32'(grant_lsb);
    stat_conf_d = stat_conf_q + 32'(arb_en && alu_ne && lsb_ne);
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      stat_alu_q  <= '0;
      stat_lsb_q  <= '0;
      stat_conf_q <= '0;
    end else begin
      stat_alu_q  <= stat_alu_d;
      stat_lsb_q  <= stat_lsb_d;
      stat_conf_q <= stat_conf_d;
    end
  end

  assign Stat_alu_grants = stat_alu_q;
  assign Stat_lsb_grants = stat_lsb_q;
  assign Stat_conflicts  = stat_conf_q;
`endif

  assign bus.CDBALU_full   = alu_full;
  assign bus.CDBLSB_full   = lsb_full;
  assign bus.CDB_en        = cdb_en_q;
  assign bus.CDB_RoB_index = cdb_idx_q;
  assign bus.CDB_value     = cdb_val_q;
  assign bus.CDB_next_pc   = cdb_npc_q;
  assign bus.CDB_src       = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin order, full/back-pressure,
// flush, freeze and asynchronous reset, with hand-computed expected values.
module tb_cdb_arbiter;

  logic clk;
  logic rst;
  logic rdy;
  int   n_total;
  int   n_bad;
  int   alu_viol;
  int   lsb_viol;
  logic [40:0] exp_q[$];

  cdb_arbiter_if #(.ADDR_WIDTH(32), .RoB_WIDTH(8)) bus ();

`ifdef CDB_ARB_STATS_EN
  logic [31:0] st_alu, st_lsb, st_conf;
`endif

  cdb_arbiter #(.ADDR_WIDTH(32), .RoB_WIDTH(8), .FIFO_WIDTH(2)) dut (
    .Sys_clk         (clk),
    .Sys_rst         (rst),
    .Sys_rdy         (rdy),
`ifdef CDB_ARB_STATS_EN
    .Stat_alu_grants (st_alu),
    .Stat_lsb_grants (st_lsb),
    .Stat_conflicts  (st_conf),
`endif
    .bus             (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // producer protocol monitor: pushing into a full FIFO
  initial begin
    alu_viol = 0;
    lsb_viol = 0;
  end
  always @(posedge clk) begin
    if (!rst && bus.ALUCDB_en && bus.CDBALU_full) alu_viol <= alu_viol + 1;
    if (!rst && bus.LSBCDB_en && bus.CDBLSB_full) lsb_viol <= lsb_viol + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.ALUCDB_en        = 1'b0;
    bus.ALUCDB_RoB_index = '0;
    bus.ALUCDB_value     = '0;
    bus.ALUCDB_next_pc   = '0;
    bus.LSBCDB_en        = 1'b0;
    bus.LSBCDB_RoB_index = '0;
    bus.LSBCDB_value     = '0;
    bus.RoBCDB_flush     = 1'b0;
  endtask

  task automatic alu_drive(input logic [7:0] idx, input logic [31:0] val, input logic [31:0] npc);
    bus.ALUCDB_en        = 1'b1;
    bus.ALUCDB_RoB_index = idx;
    bus.ALUCDB_value     = val;
    bus.ALUCDB_next_pc   = npc;
  endtask

  task automatic lsb_drive(input logic [7:0] idx, input logic [31:0] val);
    bus.LSBCDB_en        = 1'b1;
    bus.LSBCDB_RoB_index = idx;
    bus.LSBCDB_value     = val;
  endtask

  function automatic logic [9:0] head();
    return {bus.CDB_en, bus.CDB_src, bus.CDB_RoB_index};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int a_n, l_n;
    logic a_acc, l_acc;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    repeat (2) @(negedge clk);

    // reset state
    check("rst_en",    bus.CDB_en, 0);
    check("rst_idx",   bus.CDB_RoB_index, 0);
    check("rst_val",   bus.CDB_value, 0);
    check("rst_npc",   bus.CDB_next_pc, 0);
    check("rst_src",   bus.CDB_src, 0);
    check("rst_full",  {bus.CDBALU_full, bus.CDBLSB_full}, 2'b00);
    rst = 1'b0;
    tick();

    // single ALU result: one-cycle latency, then bus idles
    alu_drive(8'd5, 32'h1234, 32'h100);
    tick();
    idle();
    check("t1_lat0", bus.CDB_en, 0);
    tick();
    check("t1_head", head(), {1'b1, 1'b0, 8'd5});
    check("t1_val",  bus.CDB_value, 32'h1234);
    check("t1_npc",  bus.CDB_next_pc, 32'h100);
    tick();
    check("t1_idle", bus.CDB_en, 0);

    // single LSB result: next_pc forced to 0
    lsb_drive(8'd9, 32'h99);
    tick();
    idle();
    tick();
    check("lsb_head", head(), {1'b1, 1'b1, 8'd9});
    check("lsb_npc",  bus.CDB_next_pc, 0);
    check("lsb_val",  bus.CDB_value, 32'h99);
    tick();
    check("lsb_idle", bus.CDB_en, 0);

    // simultaneous arrival after an LSB grant: ALU first
    alu_drive(8'd1, 32'h11, 32'h200);
    lsb_drive(8'd2, 32'h22);
    tick();
    idle();
    tick();
    check("t2_first",  head(), {1'b1, 1'b0, 8'd1});
    tick();
    check("t2_second", head(), {1'b1, 1'b1, 8'd2});
    tick();
    check("t2_idle", bus.CDB_en, 0);

    // sustained contention with one deliberate push into a full ALU FIFO at cycle 8
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b0, 8'(8'h10 + i), 32'(32'hA000 + i)});
      exp_q.push_back({1'b1, 8'(8'h20 + i), 32'(32'hB000 + i)});
    end
    a_n = 0;
    l_n = 0;
    for (int c = 1; c <= 40; c++) begin
      idle();
      a_acc = 1'b0;
      l_acc = 1'b0;
      if (c == 8) begin
        alu_drive(8'h3F, 32'hDEAD, 32'h0);
      end else if (a_n < 8 && !bus.CDBALU_full) begin
        alu_drive(8'(8'h10 + a_n), 32'(32'hA000 + a_n), 32'h0);
        a_acc = 1'b1;
      end
      if (l_n < 8 && !bus.CDBLSB_full) begin
        lsb_drive(8'(8'h20 + l_n), 32'(32'hB000 + l_n));
        l_acc = 1'b1;
      end
      tick();
      if (a_acc) a_n++;
      if (l_acc) l_n++;
      if (bus.CDB_en) begin
        if (exp_q.size() == 0) check("t3_extra", 1, 0);
        else check("t3_bcast", {bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value}, exp_q.pop_front());
      end
      if (c == 6) check("t3_full6", {bus.CDBALU_full, bus.CDBLSB_full}, 2'b01);
      if (c == 7) check("t3_full7", {bus.CDBALU_full, bus.CDBLSB_full}, 2'b10);
      if (c == 8) check("t3_full8", {bus.CDBALU_full, bus.CDBLSB_full}, 2'b01);
    end
    idle();
    check("t3_drained", exp_q.size(), 0);

    // three queued, flush with a same-cycle ALU push
    alu_drive(8'h31, 32'h31, 32'h0);
    lsb_drive(8'h32, 32'h32);
    tick();
    alu_drive(8'h33, 32'h33, 32'h0);
    lsb_drive(8'h34, 32'h34);
    tick();
    check("t5_pre", head(), {1'b1, 1'b0, 8'h31});
    idle();
    alu_drive(8'h35, 32'h35, 32'h0);
    bus.RoBCDB_flush = 1'b1;
    tick();
    idle();
    check("t5_flush_en",   bus.CDB_en, 0);
    check("t5_flush_full", {bus.CDBALU_full, bus.CDBLSB_full}, 2'b00);
    tick();
    check("t5_empty1", bus.CDB_en, 0);
    tick();
    check("t5_empty2", bus.CDB_en, 0);

    // last grant was ALU before the flush, so LSB wins this tie
    alu_drive(8'h61, 32'h61, 32'h0);
    lsb_drive(8'h62, 32'h62);
    tick();
    idle();
    tick();
    check("t5_keep1", head(), {1'b1, 1'b1, 8'h62});
    tick();
    check("t5_keep2", head(), {1'b1, 1'b0, 8'h61});
    tick();
    check("t5_idle", bus.CDB_en, 0);

    // freeze with two queued
    lsb_drive(8'h70, 32'h7070);
    tick();
    idle();
    tick();
    check("t6_prime", head(), {1'b1, 1'b1, 8'h70});
    alu_drive(8'h71, 32'h7171, 32'h300);
    lsb_drive(8'h72, 32'h7272);
    tick();
    idle();
    rdy = 1'b0;
    #1;
    check("t6_full", {bus.CDBALU_full, bus.CDBLSB_full}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_frz_en",  bus.CDB_en, 0);
      check("t6_frz_val", bus.CDB_value, 32'h7070);
    end
    rdy = 1'b1;
    tick();
    check("t6_res1", head(), {1'b1, 1'b0, 8'h71});
    check("t6_npc",  bus.CDB_next_pc, 32'h300);
    tick();
    check("t6_res2", head(), {1'b1, 1'b1, 8'h72});
    tick();
    check("t6_idle", bus.CDB_en, 0);

    // asynchronous reset mid-operation
    alu_drive(8'h80, 32'h80, 32'h400);
    tick();
    alu_drive(8'h81, 32'h81, 32'h404);
    tick();
    idle();
    check("t7_pre", head(), {1'b1, 1'b0, 8'h80});
    #2 rst = 1'b1;
    #1;
    check("t7_async", {bus.CDB_en, bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value, bus.CDB_next_pc}, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t7_lost", bus.CDB_en, 0);
    alu_drive(8'h91, 32'h91, 32'h0);
    lsb_drive(8'h92, 32'h92);
    tick();
    idle();
    tick();
    check("t7_tie1", head(), {1'b1, 1'b0, 8'h91});
    tick();
    check("t7_tie2", head(), {1'b1, 1'b1, 8'h92});
    tick();

    check("viol", {alu_viol[31:0], lsb_viol[31:0]}, {32'd1, 32'd0});

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
